// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Detects load-use and branch-operand hazards on the ID instruction, issues
// multi-cycle stalls, flushes wrong-path fetches on ID redirects, and freezes
// the whole pipeline while a data-memory access in MEM is outstanding.
//
// Optional feature macro: HAZARD_PERF_EN adds three wrapping performance
// counters (stall_cycles, flush_count, memwait_cycles), each CNT_W bits wide.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rs1, rs2, use_rs1/2       ID source registers and their read enables
//   id_is_ctrl                ID instruction is BRANCH/JALR/JUMP (resolves in ID)
//   branch_taken              ID redirect; the fetched instruction is wrong-path
//   ID_EX_*, EX_MEM_*         producer info for the instructions in EX and MEM
//   mem_req, mem_ready        data-memory access in MEM and its completion
//   pc_write .. ex_mem_write  pipeline register enables (combinational)
//   if_id_flush, id_ex_flush  bubble insertion (combinational)
//   state                     RUN=0, STALL=1, MEMWAIT=2
module hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic       id_is_ctrl,
    input  logic       branch_taken,
    input  logic [4:0] ID_EX_rd,
    input  logic       ID_EX_RegWrite,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] EX_MEM_rd,
    input  logic       EX_MEM_RegWrite,
    input  logic       EX_MEM_MemRead,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       id_ex_write,
    output logic       ex_mem_write,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic [1:0] state
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] memwait_cycles
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        MEMWAIT = 2'd2
    } hazState_e;

    hazState_e  curState, nextState, savedState, nextSaved;
    logic [1:0] stallCnt, nextCnt, stallLen;
    logic       idExMatch, exMemMatch, freeze;
    logic       stallNow, redirectNow, frozenNow;

    assign state = curState;

    // Hazard detection, next-state and output decode
    always_comb begin
        idExMatch  = ID_EX_RegWrite && (ID_EX_rd != 5'd0) &&
                     (((ID_EX_rd == rs1) && use_rs1) || ((ID_EX_rd == rs2) && use_rs2));
        exMemMatch = EX_MEM_RegWrite && (EX_MEM_rd != 5'd0) &&
                     (((EX_MEM_rd == rs1) && use_rs1) || ((EX_MEM_rd == rs2) && use_rs2));

        // Priority order gives the largest applicable stall length
        stallLen = 2'd0;
        if (idExMatch && ID_EX_MemRead && id_is_ctrl)
            stallLen = 2'd3;
        else if (exMemMatch && EX_MEM_MemRead && id_is_ctrl)
            stallLen = 2'd2;
        else if (idExMatch && (id_is_ctrl || ID_EX_MemRead))
            stallLen = 2'd1;

        freeze       = mem_req && !mem_ready;
        nextState    = curState;
        nextSaved    = savedState;
        nextCnt      = stallCnt;
        stallNow     = 1'b0;
        redirectNow  = 1'b0;
        frozenNow    = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;

        if (curState == MEMWAIT) begin
            frozenNow = 1'b1;
            if (mem_ready)
                nextState = savedState;
        end else if (freeze) begin
            frozenNow = 1'b1;
            nextState = MEMWAIT;
            nextSaved = curState;
        end else if (curState == STALL) begin
            stallNow = 1'b1;
            nextCnt  = stallCnt - 2'd1;
            if (stallCnt == 2'd1)
                nextState = RUN;
        end else if (stallLen != 2'd0) begin
            stallNow  = 1'b1;
            nextCnt   = stallLen - 2'd1;
            nextState = (stallLen > 2'd1) ? STALL : RUN;
        end else if (branch_taken) begin
            redirectNow = 1'b1;
            if_id_flush = 1'b1;
        end

        if (frozenNow) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
        end
        if (stallNow) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end

        // Reset holds fetch and flushes both front registers
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end
    end

    // State, remaining-stall counter and the state interrupted by a freeze
    always_ff @(posedge clk) begin
        if (rst) begin
            curState   <= RUN;
            savedState <= RUN;
            stallCnt   <= 2'd0;
        end else begin
            curState   <= nextState;
            savedState <= nextSaved;
            stallCnt   <= nextCnt;
        end
    end

`ifdef HAZARD_PERF_EN
    // Wrapping event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles   <= '0;
            flush_count    <= '0;
            memwait_cycles <= '0;
        end else begin
            if (stallNow)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (redirectNow)
                flush_count <= flush_count + CNT_W'(1);
            if (frozenNow)
                memwait_cycles <= memwait_cycles + CNT_W'(1);
        end
    end
`else
    logic unusedCntW;
    assign unusedCntW = ^CNT_W;
`endif

endmodule
